// File: rtl/control_seq.sv
// -----------------------------------------------------------------------------
// control_seq -- instruction-cycle sequencer for the 8-bit microcontroller.
//
// A ring counter steps T1..T6. Fetch (T1-T3) is identical for every opcode.
// Execute (T4-T6) decodes the IR opcode into datapath control strobes.
// HLT parks the machine in a HALT state that only clr can leave.
//
// Opcode map: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF, others NOP.
//
// Build option:
//   SEQ_EARLY_END_EN  defined   -> each instruction returns to T1 right after
//                                  its last state with active strobes
//                                  (LDA 5, ADD/SUB 6, OUT/NOP 4 clocks).
//                     undefined -> every non-HLT instruction takes 6 clocks.
//
// Ports:
//   clk          in   system clock, all state changes on posedge
//   clr          in   synchronous active-high reset, returns ring to T1
//   instruction  in   4-bit opcode from the IR upper nibble (valid T4-T6)
//   t_state      out  one-hot ring state, bit0=T1 .. bit5=T6, zero in HALT
//   Cp, Ep       out  PC increment / PC drives bus
//   Lm           out  MAR load
//   CE           out  RAM drives bus
//   Li, Ei       out  IR load / IR address nibble drives bus
//   La, Ea       out  accumulator load / accumulator drives bus
//   Su, Eu       out  ALU subtract select / ALU drives bus
//   Lb           out  B register load
//   Lo           out  output register load
//   hlt          out  high while halted
// -----------------------------------------------------------------------------
module control_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] instruction,
  output logic [5:0] t_state,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       hlt
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_T1;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: begin
        if (instruction == OP_HLT) begin
          state_d = S_HALT;
        end else begin
`ifdef SEQ_EARLY_END_EN
          // Only LDA/ADD/SUB have strobes beyond T4.
          if ((instruction == OP_LDA) || (instruction == OP_ADD) ||
              (instruction == OP_SUB)) begin
            state_d = S_T5;
          end else begin
            state_d = S_T1;
          end
`else
          state_d = S_T5;
`endif
        end
      end
      S_T5: begin
`ifdef SEQ_EARLY_END_EN
          // LDA finishes in T5; ADD/SUB still need the ALU write-back in T6.
        state_d = (instruction == OP_LDA) ? S_T1 : S_T6;
`else
        state_d = S_T6;
`endif
      end
      S_T6:   state_d = S_T1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_T1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: combinational from state and opcode, silenced during clr.
  // Each state enables at most one bus driver (Ep, CE, Ei, Ea, Eu).
  // ---------------------------------------------------------------------------
  always_comb begin
    t_state = 6'b000000;
    hlt     = 1'b0;
    Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; CE = 1'b0; Li = 1'b0; Ei = 1'b0;
    La = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;

    unique case (state_q)
      S_T1:   t_state = 6'b000001;
      S_T2:   t_state = 6'b000010;
      S_T3:   t_state = 6'b000100;
      S_T4:   t_state = 6'b001000;
      S_T5:   t_state = 6'b010000;
      S_T6:   t_state = 6'b100000;
      S_HALT: hlt     = 1'b1;
      default: t_state = 6'b000000;
    endcase

    if (!clr) begin
      unique case (state_q)
        S_T1: begin
          Ep = 1'b1;
          Lm = 1'b1;
        end
        S_T2: Cp = 1'b1;
        S_T3: begin
          CE = 1'b1;
          Li = 1'b1;
        end
        S_T4: begin
          if ((instruction == OP_LDA) || (instruction == OP_ADD) ||
              (instruction == OP_SUB)) begin
            Ei = 1'b1;
            Lm = 1'b1;
          end else if (instruction == OP_OUT) begin
            Ea = 1'b1;
            Lo = 1'b1;
          end
        end
        S_T5: begin
          if (instruction == OP_LDA) begin
            CE = 1'b1;
            La = 1'b1;
          end else if ((instruction == OP_ADD) || (instruction == OP_SUB)) begin
            CE = 1'b1;
            Lb = 1'b1;
          end
        end
        S_T6: begin
          if ((instruction == OP_ADD) || (instruction == OP_SUB)) begin
            Eu = 1'b1;
            La = 1'b1;
            Su = (instruction == OP_SUB);
          end
        end
        default: ;  // HALT: everything stays low
      endcase
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// -----------------------------------------------------------------------------
// tb_control_seq -- directed self-checking bench for control_seq.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so each sample shows the state entered at the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_control_seq;

  logic       clk;
  logic       clr;
  logic [3:0] instruction;
  logic [5:0] t_state;
  logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;

  int checks   = 0;
  int failures = 0;

  // Strobe vector layout: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam logic [11:0] S_CP = 12'h800;
  localparam logic [11:0] S_EP = 12'h400;
  localparam logic [11:0] S_LM = 12'h200;
  localparam logic [11:0] S_CE = 12'h100;
  localparam logic [11:0] S_LI = 12'h080;
  localparam logic [11:0] S_EI = 12'h040;
  localparam logic [11:0] S_LA = 12'h020;
  localparam logic [11:0] S_EA = 12'h010;
  localparam logic [11:0] S_SU = 12'h008;
  localparam logic [11:0] S_EU = 12'h004;
  localparam logic [11:0] S_LB = 12'h002;
  localparam logic [11:0] S_LO = 12'h001;
  localparam logic [11:0] S_NONE = 12'h000;

`ifdef SEQ_EARLY_END_EN
  localparam int LDA_LEN = 5;
  localparam int OUT_LEN = 4;
`else
  localparam int LDA_LEN = 6;
  localparam int OUT_LEN = 6;
`endif

  logic [11:0] st_log [0:15];
  logic [5:0]  ts_log [0:15];

  control_seq dut (
    .clk         (clk),
    .clr         (clr),
    .instruction (instruction),
    .t_state     (t_state),
    .Cp          (Cp),
    .Ep          (Ep),
    .Lm          (Lm),
    .CE          (CE),
    .Li          (Li),
    .Ei          (Ei),
    .La          (La),
    .Ea          (Ea),
    .Su          (Su),
    .Eu          (Eu),
    .Lb          (Lb),
    .Lo          (Lo),
    .hlt         (hlt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus-driver exclusivity must hold in every cycle.
  always @(negedge clk) begin
    #1;
    if (!$isunknown({Ep, CE, Ei, Ea, Eu}))
      assert ($countones({Ep, CE, Ei, Ea, Eu}) <= 1)
      else $error("FAIL bus_exclusive: drivers=%b", {Ep, CE, Ei, Ea, Eu});
  end

  function automatic logic [11:0] strobes();
    return {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};
  endfunction

  task automatic cyc(input logic c, input logic [3:0] op);
    @(negedge clk);
    clr         = c;
    instruction = op;
    #1;
  endtask

  // One clr cycle, then n cycles of the given opcode, logged from T1 onward.
  task automatic capture(input logic [3:0] op, input int n);
    cyc(1'b1, op);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, op);
      st_log[k] = strobes();
      ts_log[k] = t_state;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 4'h0);
      checks++;
      if (t_state !== 6'b000001 || strobes() !== S_NONE || hlt !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold%0d: t_state=%b strobes=%h hlt=%b, want 000001/000/0",
                 k, t_state, strobes(), hlt);
      end
    end
    cyc(1'b0, 4'h0);
    checks++;
    if (t_state !== 6'b000001 || strobes() !== (S_EP | S_LM)) begin
      failures++;
      $display("FAIL fetch_t1: t_state=%b strobes=%h, want 000001/%h",
               t_state, strobes(), S_EP | S_LM);
    end
    cyc(1'b0, 4'h0);
    checks++;
    if (t_state !== 6'b000010 || strobes() !== S_CP) begin
      failures++;
      $display("FAIL fetch_t2: t_state=%b strobes=%h, want 000010/%h",
               t_state, strobes(), S_CP);
    end
    cyc(1'b0, 4'h0);
    checks++;
    if (t_state !== 6'b000100 || strobes() !== (S_CE | S_LI)) begin
      failures++;
      $display("FAIL fetch_t3: t_state=%b strobes=%h, want 000100/%h",
               t_state, strobes(), S_CE | S_LI);
    end
  endtask

  task automatic test_lda();
    int period;
    capture(4'h0, 8);
    checks++;
    if (st_log[3] !== (S_EI | S_LM) || ts_log[3] !== 6'b001000) begin
      failures++;
      $display("FAIL lda_t4: t_state=%b strobes=%h, want 001000/%h",
               ts_log[3], st_log[3], S_EI | S_LM);
    end
    checks++;
    if (st_log[4] !== (S_CE | S_LA)) begin
      failures++;
      $display("FAIL lda_t5: strobes=%h, want %h", st_log[4], S_CE | S_LA);
    end
    period = -1;
    for (int k = 7; k >= 1; k--) if (ts_log[k] === 6'b000001) period = k;
    checks++;
    if (period != LDA_LEN) begin
      failures++;
      $display("FAIL lda_period: got %0d clocks, want %0d", period, LDA_LEN);
    end
    checks++;
    if (st_log[LDA_LEN] !== (S_EP | S_LM)) begin
      failures++;
      $display("FAIL lda_next_fetch: strobes=%h, want %h",
               st_log[LDA_LEN], S_EP | S_LM);
    end
  endtask

  task automatic test_add_sub();
    int su_bad;
    capture(4'h2, 6);
    checks++;
    if (st_log[4] !== (S_CE | S_LB)) begin
      failures++;
      $display("FAIL sub_t5: strobes=%h, want %h", st_log[4], S_CE | S_LB);
    end
    checks++;
    if (st_log[5] !== (S_EU | S_LA | S_SU) || ts_log[5] !== 6'b100000) begin
      failures++;
      $display("FAIL sub_t6: t_state=%b strobes=%h, want 100000/%h",
               ts_log[5], st_log[5], S_EU | S_LA | S_SU);
    end
    su_bad = 0;
    for (int k = 0; k < 5; k++) if (st_log[k][3] !== 1'b0) su_bad++;
    checks++;
    if (su_bad != 0) begin
      failures++;
      $display("FAIL sub_su_other: Su high in %0d of T1..T5, want 0", su_bad);
    end

    capture(4'h1, 6);
    checks++;
    if (st_log[3] !== (S_EI | S_LM) || st_log[4] !== (S_CE | S_LB)) begin
      failures++;
      $display("FAIL add_t4_t5: strobes=%h/%h, want %h/%h",
               st_log[3], st_log[4], S_EI | S_LM, S_CE | S_LB);
    end
    checks++;
    if (st_log[5] !== (S_EU | S_LA)) begin
      failures++;
      $display("FAIL add_t6: strobes=%h, want %h", st_log[5], S_EU | S_LA);
    end
    su_bad = 0;
    for (int k = 0; k < 6; k++) if (st_log[k][3] !== 1'b0) su_bad++;
    checks++;
    if (su_bad != 0) begin
      failures++;
      $display("FAIL add_su: Su high in %0d cycles, want 0", su_bad);
    end
  endtask

  task automatic test_out_hlt();
    int bad;
    cyc(1'b1, 4'hE);
    for (int k = 0; k < OUT_LEN; k++) begin
      cyc(1'b0, 4'hE);
      if (k == 3) begin
        checks++;
        if (strobes() !== (S_EA | S_LO) || t_state !== 6'b001000) begin
          failures++;
          $display("FAIL out_t4: t_state=%b strobes=%h, want 001000/%h",
                   t_state, strobes(), S_EA | S_LO);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'hF);
      if (k == 0) begin
        checks++;
        if (t_state !== 6'b000001) begin
          failures++;
          $display("FAIL out_period: t_state=%b after %0d clocks, want 000001",
                   t_state, OUT_LEN);
        end
      end
      if (k == 3) begin
        checks++;
        if (t_state !== 6'b001000 || strobes() !== S_NONE || hlt !== 1'b0) begin
          failures++;
          $display("FAIL hlt_t4: t_state=%b strobes=%h hlt=%b, want 001000/000/0",
                   t_state, strobes(), hlt);
        end
      end
    end
    cyc(1'b0, 4'hF);
    checks++;
    if (hlt !== 1'b1 || t_state !== 6'b000000 || strobes() !== S_NONE) begin
      failures++;
      $display("FAIL hlt_entry: hlt=%b t_state=%b strobes=%h, want 1/000000/000",
               hlt, t_state, strobes());
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 4'(k));
      if (hlt !== 1'b1 || t_state !== 6'b000000 || strobes() !== S_NONE) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hlt_hold: %0d of 20 cycles left HALT or strobed, want 0", bad);
    end
    cyc(1'b1, 4'hF);
    cyc(1'b0, 4'h0);
    checks++;
    if (t_state !== 6'b000001 || hlt !== 1'b0 || strobes() !== (S_EP | S_LM)) begin
      failures++;
      $display("FAIL hlt_clear: t_state=%b hlt=%b strobes=%h, want 000001/0/%h",
               t_state, hlt, strobes(), S_EP | S_LM);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 4'h1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 4'h1);
    cyc(1'b1, 4'h1);  // clr lands in T5
    checks++;
    if (t_state !== 6'b010000 || strobes() !== S_NONE) begin
      failures++;
      $display("FAIL mid_clr_t5: t_state=%b strobes=%h, want 010000/000",
               t_state, strobes());
    end
    cyc(1'b0, 4'h1);
    checks++;
    if (t_state !== 6'b000001 || strobes() !== (S_EP | S_LM)) begin
      failures++;
      $display("FAIL mid_clr_next: t_state=%b strobes=%h, want 000001/%h",
               t_state, strobes(), S_EP | S_LM);
    end
  endtask

  task automatic test_random();
    int         instr_cnt = 0;
    int         cyc_cnt   = 0;
    logic [3:0] op        = 4'h0;
    logic       prev_t1   = 1'b0;
    logic       need_clr  = 1'b1;
    int         excl_bad  = 0;
    int         ts_bad    = 0;
    while (instr_cnt < 1000 && cyc_cnt < 20000) begin
      // Opcode changes only in T2, so it is stable through execute.
      if (prev_t1) op = 4'($urandom_range(0, 15));
      cyc(need_clr, op);
      cyc_cnt++;
      if ($countones({Ep, CE, Ei, Ea, Eu}) > 1) excl_bad++;
      if (!$onehot0(t_state) || ((t_state === 6'b000000) !== (hlt === 1'b1)))
        ts_bad++;
      if (t_state === 6'b000001 && !need_clr) instr_cnt++;
      prev_t1  = (t_state === 6'b000001);
      need_clr = (hlt === 1'b1) && !need_clr;
    end
    checks++;
    if (excl_bad != 0) begin
      failures++;
      $display("FAIL rand_exclusive: %0d cycles with multiple bus drivers, want 0",
               excl_bad);
    end
    checks++;
    if (ts_bad != 0) begin
      failures++;
      $display("FAIL rand_t_state: %0d cycles with bad t_state/hlt, want 0", ts_bad);
    end
    checks++;
    if (instr_cnt < 1000) begin
      failures++;
      $display("FAIL rand_progress: %0d instructions in %0d cycles, want 1000",
               instr_cnt, cyc_cnt);
    end
  endtask

  initial begin
    clr         = 1'b1;
    instruction = 4'h0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out_hlt();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_seq.md
# control_seq

Instruction-cycle sequencer for the 8-bit microcontroller. A 6-state ring counter (T1..T6) is combined with the 4-bit opcode from the instruction register to produce every datapath control strobe: program counter, memory address register, RAM, IR, accumulator, B register, ALU and output port. Fetch runs in T1–T3 and execute in T4–T6. HLT freezes the machine until reset.

## Interface
Parameters:
- none (opcode map fixed: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF, all others NOP)

Ports:
- clk  in  1  system clock; all state changes on posedge
- clr  in  1  reset; one clock, synchronous, active-high
- instruction  in  4  opcode from IR upper nibble; sampled combinationally in T4–T6
- t_state  out  6  one-hot ring state, bit0=T1 … bit5=T6; 6'b000000 while halted
- Cp  out  1  PC increment
- Ep  out  1  PC drives bus
- Lm  out  1  MAR load
- CE  out  1  RAM drives bus
- Li  out  1  IR load
- Ei  out  1  IR address nibble drives bus
- La  out  1  accumulator load
- Ea  out  1  accumulator drives bus
- Su  out  1  ALU subtract select
- Eu  out  1  ALU drives bus
- Lb  out  1  B register load
- Lo  out  1  output register load
- hlt  out  1  halted flag

## Operation
- Control outputs are combinational from t_state and instruction. They are forced to 0 while clr=1 or while halted.
- Fetch, identical for all opcodes:
  - T1: Ep, Lm
  - T2: Cp
  - T3: CE, Li
- Execute per opcode:
  - LDA: T4 Ei,Lm; T5 CE,La; T6 none
  - ADD: T4 Ei,Lm; T5 CE,Lb; T6 Eu,La
  - SUB: same as ADD, plus Su=1 in T6
  - OUT: T4 Ea,Lo; T5–T6 none
  - NOP: T4–T6 none
  - HLT: T4 has no strobes; next state is HALT
- States: T1→T2→T3→T4→T5→T6→T1. From T4 with opcode HLT the next state is HALT. HALT is absorbing except for clr.
- hlt=1 exactly while in HALT. In HALT, t_state=0 and all strobes are 0.
- Invariant: at most one of {Ep, CE, Ei, Ea, Eu} is 1 in any cycle. This is a bus-driver exclusivity rule; the bench asserts it.
- Opcode is assumed stable from T4 through the end of execute, because the IR loads only in T3.

## Timing
- Reset: clr=1 at a posedge gives t_state=6'b000001 (T1) and hlt=0 after that edge. Outputs are 0 during the clr cycle.
- clr in any state, including mid-execute or HALT, aborts the instruction. No partial strobes follow; the next cycle is T1.
- Strobes are valid for the whole state cycle. The receiving registers capture at the posedge that ends the state.
- IR captures at the end of T3, so instruction is valid from T4.
- Fixed instruction length: 6 clocks. HLT takes 4 clocks from T1 to HALT entry; hlt asserts on the 5th cycle.
- After clr deasserts: first T1 strobes appear in the cycle following the reset edge.

## Configuration
- Macro: SEQ_EARLY_END_EN.
- Defined — variable-length execute. The ring returns to T1 right after the last state that has active strobes:
  - LDA: T5→T1 (5 clocks)
  - ADD/SUB: T6→T1 (6 clocks)
  - OUT: T4→T1 (4 clocks)
  - NOP: T4→T1 (4 clocks)
  - HLT: unchanged
- Undefined — every non-HLT instruction runs T1..T6 (6 clocks).
- Strobe content per state is identical in both builds.

## Test plan
- Reset: hold clr=1 for 2 cycles, then release. Required: t_state=000001 and all strobes 0 during clr; cycle 1 after release has Ep=Lm=1; cycle 2 has Cp=1; cycle 3 has CE=Li=1.
- LDA (instruction=4'h0): T4 Ei=Lm=1; T5 CE=La=1. Next T1 comes after T6 (macro off) or after T5 (macro on). Check the period is 6 or 5 clocks.
- SUB (instruction=4'h2): T5 CE=Lb=1; T6 Eu=La=Su=1 and Su=0 in all other states. For ADD (4'h1), Su stays 0 throughout.
- OUT then HLT:
  - OUT: T4 Ea=Lo=1.
  - HLT (4'hF): after T4, hlt=1 and t_state=0. Hold 20 cycles: no strobes. Then clr=1 for 1 cycle: T1 resumes and hlt=0.
- Mid-instruction reset: assert clr in T5 of ADD. The next cycle is T1 with no Eu/La pulse.
- Random opcodes over 1000 instructions, including NOP values 4'h3–4'hD. Required every cycle: exclusivity invariant holds; t_state is one-hot or zero; zero only when hlt=1.
